exec_unit: RTL and testbench

- Parametrised single-issue execute stage; sits between the decoder and the memory stage.
- Accepts one decoded micro-op per handshake. Reads an operand bus (immediate, MDR or register file), runs a two-operand ALU, and writes the result to MAR, MDR or a register.
- Optionally performs one load or store through the memory port.
- Contains its own register file, MAR, MDR and flags.

---
 rtl/exec_unit.sv | 215 +++++++++++++++++++++
 tb/tb_exec_unit.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Single-issue execute stage: latches one decoded micro-op, runs it through a
// two-operand ALU into MAR/MDR/register file, then optionally does one load/store.
module exec_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20,
    parameter int NREG   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic [$clog2(NREG)-1:0]  dec_src,
    input  logic [$clog2(NREG)-1:0]  dec_dst,
    input  logic [3:0]               dec_aluop,
    input  logic [DATA_W-1:0]        dec_imm,
    input  logic [1:0]               dec_rsel,
    input  logic [1:0]               dec_wsel,
    input  logic                     dec_wen,
    input  logic [1:0]               dec_memop,
    output logic                     mem_req,
    output logic                     mem_we,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     flag_z,
    output logic                     flag_c,
    output logic                     flag_n,
    output logic                     busy
);

    localparam int REG_AW = $clog2(NREG);
    localparam int SH_W   = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MEM
    } state_t;

    typedef enum logic [3:0] {
        ALU_PASS = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_SHR  = 4'd7,
        ALU_NOT  = 4'd8
    } alu_op_t;

    localparam logic [1:0] SEL_IMM_MAR = 2'b00;
    localparam logic [1:0] SEL_MDR     = 2'b01;
    localparam logic [1:0] SEL_SRC     = 2'b10;
    localparam logic [1:0] SEL_DST     = 2'b11;

    localparam logic [1:0] MEMOP_LOAD  = 2'b01;
    localparam logic [1:0] MEMOP_STORE = 2'b10;

    state_t state;
    state_t state_next;

    logic [REG_AW-1:0] op_src;
    logic [REG_AW-1:0] op_dst;
    logic [3:0]        op_aluop;
    logic [DATA_W-1:0] op_imm;
    logic [1:0]        op_rsel;
    logic [1:0]        op_wsel;
    logic              op_wen;
    logic [1:0]        op_memop;

    logic [DATA_W-1:0] regs [NREG];
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              z_q;
    logic              c_q;
    logic              n_q;

    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W:0]   shl_ext;
    logic [DATA_W:0]   shr_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              is_mem;

    assign is_mem = (op_memop == MEMOP_LOAD) || (op_memop == MEMOP_STORE);

    // Operand A mux; operand B is always the destination register.
    always_comb begin
        opa = op_imm;
        case (op_rsel)
            SEL_IMM_MAR: opa = op_imm;
            SEL_MDR:     opa = mdr;
            SEL_SRC:     opa = regs[op_src];
            SEL_DST:     opa = regs[op_dst];
            default:     opa = op_imm;
        endcase
    end

    assign opb   = regs[op_dst];
    assign shamt = opa[SH_W-1:0];

    // Shifts run one bit wider so the last bit shifted out lands in the spare
    // bit; a zero shift leaves that bit clear, giving C=0 for free.
    always_comb begin
        alu_res = opa;
        alu_c   = 1'b0;
        shl_ext = {1'b0, opb} << shamt;
        shr_ext = {opb, 1'b0} >> shamt;
        case (op_aluop)
            ALU_PASS: alu_res = opa;
            ALU_ADD:  {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
            ALU_SUB: begin
                alu_res = opb - opa;
                alu_c   = (opa > opb);
            end
            ALU_AND:  alu_res = opa & opb;
            ALU_OR:   alu_res = opa | opb;
            ALU_XOR:  alu_res = opa ^ opb;
            ALU_SHL: begin
                alu_res = shl_ext[DATA_W-1:0];
                alu_c   = shl_ext[DATA_W];
            end
            ALU_SHR: begin
                alu_res = shr_ext[DATA_W:1];
                alu_c   = shr_ext[0];
            end
            ALU_NOT:  alu_res = ~opa;
            default:  alu_res = opa;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dec_valid) state_next = EXEC;
            EXEC:    state_next = is_mem ? MEM : IDLE;
            MEM:     if (mem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reset clears the whole architectural state, abandoning any pending access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_src   <= '0;
            op_dst   <= '0;
            op_aluop <= '0;
            op_imm   <= '0;
            op_rsel  <= '0;
            op_wsel  <= '0;
            op_wen   <= 1'b0;
            op_memop <= '0;
            mar      <= '0;
            mdr      <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (dec_valid) begin
                        op_src   <= dec_src;
                        op_dst   <= dec_dst;
                        op_aluop <= dec_aluop;
                        op_imm   <= dec_imm;
                        op_rsel  <= dec_rsel;
                        op_wsel  <= dec_wsel;
                        op_wen   <= dec_wen;
                        op_memop <= dec_memop;
                    end
                end
                EXEC: begin
                    z_q <= (alu_res == '0);
                    c_q <= alu_c;
                    n_q <= alu_res[DATA_W-1];
                    if (op_wen) begin
                        case (op_wsel)
                            SEL_IMM_MAR: mar <= ADDR_W'(alu_res);
                            SEL_MDR:     mdr <= alu_res;
                            SEL_SRC:     regs[op_src] <= alu_res;
                            SEL_DST:     regs[op_dst] <= alu_res;
                            default:     mdr <= alu_res;
                        endcase
                    end
                end
                MEM: begin
                    if (mem_ack && (op_memop == MEMOP_LOAD)) begin
                        mdr <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dec_ready = (state == IDLE);
    assign busy      = ~dec_ready;
    assign mem_req   = (state == MEM);
    assign mem_we    = (state == MEM) && (op_memop == MEMOP_STORE);
    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign flag_n    = n_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: an arithmetic reference model predicts flags,
// busy length and memory transactions; a monitor compares them as the DUT shows them.
module tb_exec_unit;

    localparam int W  = 16;
    localparam int AW = 20;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid;
    logic          dec_ready;
    logic [3:0]    dec_src;
    logic [3:0]    dec_dst;
    logic [3:0]    dec_aluop;
    logic [W-1:0]  dec_imm;
    logic [1:0]    dec_rsel;
    logic [1:0]    dec_wsel;
    logic          dec_wen;
    logic [1:0]    dec_memop;
    logic          mem_req;
    logic          mem_we;
    logic          mem_ack;
    logic [W-1:0]  mem_rdata;
    logic [W-1:0]  mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          flag_z;
    logic          flag_c;
    logic          flag_n;
    logic          busy;

    logic          b_dec_valid;
    logic          b_dec_ready;
    logic [2:0]    b_dec_src;
    logic [2:0]    b_dec_dst;
    logic [3:0]    b_dec_aluop;
    logic [31:0]   b_dec_imm;
    logic [1:0]    b_dec_rsel;
    logic [1:0]    b_dec_wsel;
    logic          b_dec_wen;
    logic [1:0]    b_dec_memop;
    logic          b_mem_req;
    logic          b_mem_we;
    logic          b_mem_ack;
    logic [31:0]   b_mem_rdata;
    logic [31:0]   b_mem_wdata;
    logic [31:0]   b_mem_addr;
    logic          b_flag_z;
    logic          b_flag_c;
    logic          b_flag_n;
    logic          b_busy;

    always #5 clk = ~clk;

    exec_unit #(.DATA_W(W), .ADDR_W(AW), .NREG(NR)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_src(dec_src), .dec_dst(dec_dst), .dec_aluop(dec_aluop),
        .dec_imm(dec_imm), .dec_rsel(dec_rsel), .dec_wsel(dec_wsel),
        .dec_wen(dec_wen), .dec_memop(dec_memop),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .busy(busy)
    );

    exec_unit #(.DATA_W(32), .ADDR_W(32), .NREG(8)) dut32 (
        .clk(clk), .rst(rst),
        .dec_valid(b_dec_valid), .dec_ready(b_dec_ready),
        .dec_src(b_dec_src), .dec_dst(b_dec_dst), .dec_aluop(b_dec_aluop),
        .dec_imm(b_dec_imm), .dec_rsel(b_dec_rsel), .dec_wsel(b_dec_wsel),
        .dec_wen(b_dec_wen), .dec_memop(b_dec_memop),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_ack(b_mem_ack),
        .mem_rdata(b_mem_rdata), .mem_wdata(b_mem_wdata), .mem_addr(b_mem_addr),
        .flag_z(b_flag_z), .flag_c(b_flag_c), .flag_n(b_flag_n), .busy(b_busy)
    );

    typedef struct {
        logic z;
        logic c;
        logic n;
        int   busyCycles;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [W-1:0]  wdata;
    } mem_t;

    typedef struct {
        int           delay;
        logic [W-1:0] data;
    } ack_t;

    exp_t expQ[$];
    mem_t memQ[$];
    ack_t ackQ[$];

    logic [W-1:0]  mreg [NR];
    logic [AW-1:0] mmar;
    logic [W-1:0]  mmdr;

    int tests = 0;
    int fails = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        mmar = '0;
        mmdr = '0;
    endtask

    // Reference ALU in plain integer arithmetic on unsigned W-bit values.
    task automatic modelAlu(input logic [3:0] op, input longint a, input longint b,
                            output longint r, output bit c);
        longint m;
        longint s;
        int sh;
        m  = longint'(1) << W;
        sh = int'(a % W);
        c  = 1'b0;
        case (op)
            4'd1: begin s = a + b; r = s % m; c = (s >= m); end
            4'd2: begin r = (b - a + m) % m; c = (a > b); end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: begin
                r = (b << sh) % m;
                c = (sh != 0) && (((b >> (W - sh)) & 1) != 0);
            end
            4'd7: begin
                r = b >> sh;
                c = (sh != 0) && (((b >> (sh - 1)) & 1) != 0);
            end
            4'd8: r = (~a) & (m - 1);
            default: r = a;
        endcase
    endtask

    task automatic applyStimulus(input logic [3:0] src, input logic [3:0] dst, input logic [3:0] aluop,
                                 input logic [W-1:0] imm, input logic [1:0] rsel, input logic [1:0] wsel,
                                 input logic wen, input logic [1:0] memop, input int delay,
                                 input logic [W-1:0] rdata);
        longint a;
        longint b;
        longint r;
        bit     c;
        exp_t   e;
        mem_t   m;
        ack_t   k;
        int     n;
        logic   rdy;
        case (rsel)
            2'b00:   a = longint'(imm);
            2'b01:   a = longint'(mmdr);
            2'b10:   a = longint'(mreg[src]);
            default: a = longint'(mreg[dst]);
        endcase
        b = longint'(mreg[dst]);
        modelAlu(aluop, a, b, r, c);
        e.z = (r == 0);
        e.c = c;
        e.n = ((r >> (W - 1)) & 1) != 0;
        e.busyCycles = 1;
        if (wen) begin
            case (wsel)
                2'b00:   mmar = AW'(r);
                2'b01:   mmdr = W'(r);
                2'b10:   mreg[src] = W'(r);
                default: mreg[dst] = W'(r);
            endcase
        end
        if (memop == 2'b01 || memop == 2'b10) begin
            m.addr  = mmar;
            m.we    = (memop == 2'b10);
            m.wdata = mmdr;
            memQ.push_back(m);
            k.delay = delay;
            k.data  = rdata;
            ackQ.push_back(k);
            e.busyCycles += delay + 1;
            if (memop == 2'b01) mmdr = rdata;
        end
        expQ.push_back(e);

        dec_src   = src;
        dec_dst   = dst;
        dec_aluop = aluop;
        dec_imm   = imm;
        dec_rsel  = rsel;
        dec_wsel  = wsel;
        dec_wen   = wen;
        dec_memop = memop;
        dec_valid = 1'b1;
        n = 0;
        do begin
            rdy = dec_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        if (!rdy) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: dec_ready stayed 0 for %0d cycles, required 1", n);
        end
        dec_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || !dec_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain", 64'(expQ.size()), 64'd0);
    endtask

    task automatic bIssue(input logic [3:0] src, input logic [3:0] dst, input logic [3:0] aluop,
                          input logic [31:0] imm, input logic [1:0] rsel, input logic [1:0] wsel,
                          input logic [1:0] memop);
        int   n;
        logic rdy;
        b_dec_src   = src[2:0];
        b_dec_dst   = dst[2:0];
        b_dec_aluop = aluop;
        b_dec_imm   = imm;
        b_dec_rsel  = rsel;
        b_dec_wsel  = wsel;
        b_dec_wen   = 1'b1;
        b_dec_memop = memop;
        b_dec_valid = 1'b1;
        n = 0;
        do begin
            rdy = b_dec_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            tests++;
            fails++;
            $display("[TB] FAIL b_accept_timeout: dec_ready stayed 0, required 1");
        end
        b_dec_valid = 1'b0;
    endtask

    // Memory model: acknowledges each request after the delay queued with it.
    initial begin
        ack_t k;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !rst) begin
                k.delay = 0;
                k.data  = '0;
                if (ackQ.size() != 0) k = ackQ.pop_front();
                repeat (k.delay) begin
                    @(posedge clk);
                    #1;
                end
                mem_rdata = k.data;
                mem_ack   = 1'b1;
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
            end
        end
    end

    // Monitor: checks each new memory request and each op's completion.
    initial begin
        int   busyCnt;
        logic prevReady;
        logic prevReq;
        exp_t e;
        mem_t m;
        busyCnt   = 0;
        prevReady = 1'b1;
        prevReq   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busyCnt   = 0;
                prevReady = 1'b1;
                prevReq   = 1'b0;
            end else begin
                if (mem_req && !prevReq) begin
                    if (memQ.size() == 0) begin
                        checkOutput("unexpected_mem_req", 64'(mem_req), 64'd0);
                    end else begin
                        m = memQ.pop_front();
                        checkOutput("mem_addr", 64'(mem_addr), 64'(m.addr));
                        checkOutput("mem_we", 64'(mem_we), 64'(m.we));
                        checkOutput("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
                    end
                end
                if (!dec_ready) begin
                    busyCnt++;
                end else if (!prevReady) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_completion", 64'd1, 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("flag_z", 64'(flag_z), 64'(e.z));
                        checkOutput("flag_c", 64'(flag_c), 64'(e.c));
                        checkOutput("flag_n", 64'(flag_n), 64'(e.n));
                        checkOutput("busy_cycles", 64'(busyCnt), 64'(e.busyCycles));
                    end
                    busyCnt = 0;
                end
                prevReady = dec_ready;
                prevReq   = mem_req;
            end
        end
    end

    initial begin
        logic [3:0] idx9;
        rst = 1'b1;
        dec_valid = 1'b0; dec_src = '0; dec_dst = '0; dec_aluop = '0; dec_imm = '0;
        dec_rsel = '0; dec_wsel = '0; dec_wen = 1'b0; dec_memop = '0;
        b_dec_valid = 1'b0; b_dec_src = '0; b_dec_dst = '0; b_dec_aluop = '0; b_dec_imm = '0;
        b_dec_rsel = '0; b_dec_wsel = '0; b_dec_wen = 1'b0; b_dec_memop = '0;
        b_mem_ack = 1'b0; b_mem_rdata = '0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_dec_ready", 64'(dec_ready), 64'd1);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
        checkOutput("reset_flags", 64'({flag_z, flag_c, flag_n}), 64'd0);

        // Directed: PASS imm to R3, R3 to MDR, expose MDR with a store.
        applyStimulus(4'd0, 4'd3, 4'd0, 16'h1234, 2'b00, 2'b11, 1'b1, 2'b00, 0, 16'h0);
        applyStimulus(4'd3, 4'd0, 4'd0, 16'h0000, 2'b10, 2'b01, 1'b1, 2'b00, 0, 16'h0);
        applyStimulus(4'd0, 4'd0, 4'd0, 16'h0000, 2'b01, 2'b01, 1'b1, 2'b10, 0, 16'h0);
        // ADD wrap with carry, then SUB borrow.
        applyStimulus(4'd0, 4'd1, 4'd0, 16'hFFFF, 2'b00, 2'b11, 1'b1, 2'b00, 0, 16'h0);
        applyStimulus(4'd0, 4'd2, 4'd0, 16'h0001, 2'b00, 2'b11, 1'b1, 2'b00, 0, 16'h0);
        applyStimulus(4'd1, 4'd2, 4'd1, 16'h0000, 2'b10, 2'b11, 1'b1, 2'b00, 0, 16'h0);
        applyStimulus(4'd0, 4'd2, 4'd2, 16'h0002, 2'b00, 2'b11, 1'b1, 2'b00, 0, 16'h0);
        // Store with a three-cycle request, next op offered during MEM.
        applyStimulus(4'd0, 4'd0, 4'd0, 16'hABCD, 2'b00, 2'b00, 1'b1, 2'b00, 0, 16'h0);
        applyStimulus(4'd0, 4'd0, 4'd0, 16'h5555, 2'b00, 2'b01, 1'b1, 2'b00, 0, 16'h0);
        applyStimulus(4'd0, 4'd0, 4'd0, 16'h0000, 2'b00, 2'b00, 1'b0, 2'b10, 2, 16'h0);
        // Load then move MDR into R5 and expose R5.
        applyStimulus(4'd0, 4'd0, 4'd0, 16'h0010, 2'b00, 2'b00, 1'b1, 2'b00, 0, 16'h0);
        applyStimulus(4'd0, 4'd0, 4'd0, 16'h0000, 2'b00, 2'b00, 1'b0, 2'b01, 1, 16'hBEEF);
        applyStimulus(4'd0, 4'd5, 4'd0, 16'h0000, 2'b01, 2'b11, 1'b1, 2'b00, 0, 16'h0);
        applyStimulus(4'd5, 4'd0, 4'd0, 16'h0000, 2'b10, 2'b01, 1'b1, 2'b10, 0, 16'h0);

        for (int i = 0; i < 200; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), W'($urandom),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), W'($urandom));
        end
        waitDrain();

        // Reset in the middle of a long store; its late ack must be ignored.
        applyStimulus(4'd0, 4'd0, 4'd0, 16'h0000, 2'b01, 2'b01, 1'b1, 2'b10, 6, 16'h0);
        @(posedge clk);
        #1;
        checkOutput("mid_mem_req", 64'(mem_req), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        memQ.delete();
        ackQ.delete();
        resetModel();
        checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("rst_dec_ready", 64'(dec_ready), 64'd1);
        checkOutput("rst_flags", 64'({flag_z, flag_c, flag_n}), 64'd0);
        repeat (10) begin
            @(posedge clk);
            #1;
            if (mem_req) checkOutput("late_ack_mem_req", 64'(mem_req), 64'd0);
        end
        applyStimulus(4'd0, 4'd0, 4'd0, 16'h0000, 2'b01, 2'b00, 1'b1, 2'b10, 0, 16'h0);
        applyStimulus(4'd3, 4'd0, 4'd0, 16'h0000, 2'b10, 2'b01, 1'b1, 2'b10, 0, 16'h0);
        waitDrain();

        // Wide instance: index 9 aliases R1, SHL carries out the MSB.
        idx9 = 4'd9;
        bIssue(4'd0, idx9, 4'd0, 32'h8000_0001, 2'b00, 2'b11, 2'b00);
        @(posedge clk);
        #1;
        checkOutput("b_pass_n", 64'(b_flag_n), 64'd1);
        bIssue(4'd0, 4'd1, 4'd6, 32'd1, 2'b00, 2'b11, 2'b00);
        @(posedge clk);
        #1;
        checkOutput("b_shl_flags", 64'({b_flag_z, b_flag_c, b_flag_n}), 64'b010);
        bIssue(idx9, 4'd0, 4'd0, 32'd0, 2'b10, 2'b01, 2'b10);
        @(posedge clk);
        #1;
        checkOutput("b_mem_req", 64'(b_mem_req), 64'd1);
        checkOutput("b_mem_we", 64'(b_mem_we), 64'd1);
        checkOutput("b_shl_result", 64'(b_mem_wdata), 64'h2);
        checkOutput("b_mem_addr", 64'(b_mem_addr), 64'h0);
        b_mem_ack = 1'b1;
        @(posedge clk);
        #1;
        b_mem_ack = 1'b0;
        checkOutput("b_dec_ready", 64'(b_dec_ready), 64'd1);

        checkOutput("leftover_mem", 64'(memQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
